edge_gen: RTL and testbench

Programmable edge-train generator: on command, drives `edge_out` through COUNT+1 level transitions, the first after a programmable delay and the rest spaced by a programmable period. It is the transmit-side counterpart of the edge-count trigger and produces the exact stimulus that trigger counts, for target stimulus and for loopback self-test. It sits on the USB register bus and runs entirely in the `clk_usb` domain.

---
 rtl/edge_gen.sv | 162 ++++++++++++++++
 tb/tb_edge_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_gen.sv
// edge_gen: programmable edge-train generator on the USB register bus.
// After a start, edge_out makes COUNT+1 toggles: the first after DELAY cycles, then every max(PERIOD,1).
module edge_gen #(
  parameter int unsigned pBYTECNT_SIZE     = 7,
  parameter logic [7:0]  EdgeGenCountAddr  = 8'd80,
  parameter logic [7:0]  EdgeGenPeriodAddr = 8'd81,
  parameter logic [7:0]  EdgeGenDelayAddr  = 8'd82,
  parameter logic [7:0]  EdgeGenCtrlAddr   = 8'd83
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datai,
  output logic [7:0]               reg_datao,
  input  logic                     reg_read,
  input  logic                     reg_write,
  output logic                     edge_out,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {StIdle, StDelay, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d, period_q, period_d, delay_q, delay_d;
  logic [15:0] period_sh_q, period_sh_d, wait_q, wait_d, remain_q, remain_d;
  logic        edge_q, edge_d, done_q, done_d, sticky_q, sticky_d, abort_q, abort_d;
  logic        byte0, byte1, ctrl_wr;

  assign byte0    = (reg_bytecnt == '0);
  assign byte1    = (reg_bytecnt == pBYTECNT_SIZE'(1));
  assign ctrl_wr  = reg_write && (reg_address == EdgeGenCtrlAddr) && byte0;
  assign busy     = (state_q != StIdle);
  assign edge_out = edge_q;
  assign done     = done_q;

  function automatic logic [15:0] wr16(input logic [15:0] cur, input logic [7:0] d,
                                       input logic b0, input logic b1);
    logic [15:0] r;
    r = cur;
    if (b0) r[7:0] = d;
    if (b1) r[15:8] = d;
    return r;
  endfunction

  function automatic logic [7:0] rd16(input logic [15:0] v, input logic b0, input logic b1);
    logic [7:0] r;
    r = 8'h00;
    if (b0) r = v[7:0];
    if (b1) r = v[15:8];
    return r;
  endfunction

  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    delay_d  = delay_q;
    if (reg_write && (reg_address == EdgeGenCountAddr)) begin
      count_d = wr16(count_q, reg_datai, byte0, byte1);
    end
    if (reg_write && (reg_address == EdgeGenPeriodAddr)) begin
      period_d = wr16(period_q, reg_datai, byte0, byte1);
    end
    if (reg_write && (reg_address == EdgeGenDelayAddr)) begin
      delay_d = wr16(delay_q, reg_datai, byte0, byte1);
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    remain_d    = remain_q;
    period_sh_d = period_sh_q;
    edge_d      = edge_q;
    done_d      = 1'b0;
    sticky_d    = sticky_q;
    abort_d     = abort_q;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (ctrl_wr) begin
          edge_d = reg_datai[2];
          if (reg_datai[0] && !reg_datai[1]) begin
            wait_d      = delay_q;
            remain_d    = count_q;
            period_sh_d = (period_q == 16'd0) ? 16'd1 : period_q;
            sticky_d    = 1'b0;
            state_d     = StDelay;
          end
        end
      end
      StDelay, StRun: begin
        if (abort_q) begin
          state_d = StIdle;
          abort_d = 1'b0;
        end else if (ctrl_wr && reg_datai[1]) begin
          // Freeze for the abort cycle so a toggle due on the next edge is dropped.
          abort_d = 1'b1;
        end else if (wait_q == 16'd0) begin
          edge_d = ~edge_q;
          if (remain_q == 16'd0) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            sticky_d = 1'b1;
          end else begin
            remain_d = remain_q - 16'd1;
            wait_d   = period_sh_q - 16'd1;
            state_d  = StRun;
          end
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= 16'd0;
      period_q    <= 16'd0;
      delay_q     <= 16'd0;
      period_sh_q <= 16'd0;
      wait_q      <= 16'd0;
      remain_q    <= 16'd0;
      edge_q      <= 1'b0;
      done_q      <= 1'b0;
      sticky_q    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      period_q    <= period_d;
      delay_q     <= delay_d;
      period_sh_q <= period_sh_d;
      wait_q      <= wait_d;
      remain_q    <= remain_d;
      edge_q      <= edge_d;
      done_q      <= done_d;
      sticky_q    <= sticky_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    reg_datao = 8'h00;
    if (reg_read) begin
      if (reg_address == EdgeGenCountAddr) begin
        reg_datao = rd16(count_q, byte0, byte1);
      end else if (reg_address == EdgeGenPeriodAddr) begin
        reg_datao = rd16(period_q, byte0, byte1);
      end else if (reg_address == EdgeGenDelayAddr) begin
        reg_datao = rd16(delay_q, byte0, byte1);
      end else if ((reg_address == EdgeGenCtrlAddr) && byte0) begin
        reg_datao = {5'd0, edge_q, sticky_q, busy};
      end
    end
  end

endmodule

// File: tb/tb_edge_gen.sv
// Scoreboard bench for edge_gen: stimulus queues expected toggles, done pulses and reads;
// a negedge monitor pops and compares whenever the DUT presents one of them.
module tb_edge_gen;

  localparam logic [7:0] ACnt = 8'd80;
  localparam logic [7:0] APer = 8'd81;
  localparam logic [7:0] ADly = 8'd82;
  localparam logic [7:0] ACtl = 8'd83;
  localparam int KEdge = 0;
  localparam int KDone = 1;
  localparam int KRead = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] val;
  } ev_t;

  ev_t q[$];

  logic       clk_usb = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] reg_address = 8'h00;
  logic [6:0] reg_bytecnt = 7'd0;
  logic [7:0] reg_datai = 8'h00;
  logic [7:0] reg_datao;
  logic       reg_read = 1'b0;
  logic       reg_write = 1'b0;
  logic       edge_out, busy, done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic lvl = 1'b0;
  logic prev_edge = 1'b0;

  edge_gen #(
    .pBYTECNT_SIZE    (7),
    .EdgeGenCountAddr (ACnt),
    .EdgeGenPeriodAddr(APer),
    .EdgeGenDelayAddr (ADly),
    .EdgeGenCtrlAddr  (ACtl)
  ) dut (
    .clk_usb    (clk_usb),
    .reset      (reset),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .reg_datai  (reg_datai),
    .reg_datao  (reg_datao),
    .reg_read   (reg_read),
    .reg_write  (reg_write),
    .edge_out   (edge_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_usb = ~clk_usb;
  always @(posedge clk_usb) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input logic [7:0] v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d val 0x%02h at cycle %0d, required none",
               kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        errors++;
        $display("FAIL event: got kind %0d val 0x%02h cycle %0d, required kind %0d val 0x%02h cycle %0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: edge changes, done pulses and reads, in that order within a cycle.
  always @(negedge clk_usb) begin
    if (reset) begin
      prev_edge = edge_out;
    end else begin
      if (edge_out !== prev_edge) begin
        check_ev(KEdge, {7'd0, edge_out});
        prev_edge = edge_out;
      end
      if (done) check_ev(KDone, 8'h01);
      if (reg_read) check_ev(KRead, reg_datao);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // All stimulus tasks start and end 1ns after a rising edge.
  task automatic wr(input logic [7:0] a, input logic [6:0] b, input logic [7:0] d);
    reg_address = a;
    reg_bytecnt = b;
    reg_datai   = d;
    reg_write   = 1'b1;
    @(posedge clk_usb);
    #1 reg_write = 1'b0;
  endtask

  task automatic wr16(input logic [7:0] a, input logic [15:0] v);
    wr(a, 7'd0, v[7:0]);
    wr(a, 7'd1, v[15:8]);
  endtask

  task automatic rd(input logic [7:0] a, input logic [6:0] b, input logic [7:0] exp);
    push(KRead, cyc, exp);
    reg_address = a;
    reg_bytecnt = b;
    reg_read    = 1'b1;
    @(posedge clk_usb);
    #1 reg_read = 1'b0;
  endtask

  // CTRL write while idle; queues the level change, ntog toggles and optionally done.
  task automatic go(input logic [7:0] d, input int ntog, input int per, input int dly,
                    input bit with_done, output int k);
    int p;
    p = (per == 0) ? 1 : per;
    k = cyc + 1;
    if (d[2] !== lvl) begin
      lvl = d[2];
      push(KEdge, k, {7'd0, lvl});
    end
    for (int n = 0; n < ntog; n++) begin
      lvl = ~lvl;
      push(KEdge, k + 1 + dly + n * p, {7'd0, lvl});
    end
    if (with_done && ntog > 0) push(KDone, k + 1 + dly + (ntog - 1) * p, 8'h01);
    wr(ACtl, 7'd0, d);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_usb);
      #1;
    end
  endtask

  task automatic wait_idle(input int exp_c, input string nm);
    int n;
    n = 0;
    @(negedge clk_usb);
    while (busy && n < 2000) begin
      @(negedge clk_usb);
      n++;
    end
    checks++;
    if (busy || cyc != exp_c) begin
      errors++;
      $display("FAIL %s: busy=%0b, idle from cycle %0d, required idle from cycle %0d",
               nm, busy, cyc, exp_c);
    end
    @(posedge clk_usb);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    #3 reset = 1'b1;
    repeat (2) @(posedge clk_usb);
    #1 reset = 1'b0;

    // Registers, byte lanes and reset
    wr16(ACnt, 16'h1234);
    reg_address = ACnt;
    reg_bytecnt = 7'd0;
    #1 chk("datao_no_read", {8'd0, reg_datao}, 16'h0000);
    rd(ACnt, 7'd0, 8'h34);
    rd(ACnt, 7'd1, 8'h12);
    rd(ACnt, 7'd2, 8'h00);
    go(8'h04, 0, 0, 0, 0, k);
    rd(ACtl, 7'd0, 8'h04);
    #1 reset = 1'b1;
    #1;
    chk("reset_edge_out", {15'd0, edge_out}, 16'h0);
    chk("reset_busy", {15'd0, busy}, 16'h0);
    chk("reset_done", {15'd0, done}, 16'h0);
    lvl = 1'b0;
    @(negedge clk_usb);
    @(posedge clk_usb);
    #1 reset = 1'b0;
    rd(ACnt, 7'd0, 8'h00);
    rd(ACnt, 7'd1, 8'h00);
    rd(APer, 7'd0, 8'h00);
    rd(ADly, 7'd1, 8'h00);
    rd(ACtl, 7'd0, 8'h00);

    // COUNT=3 PERIOD=4 DELAY=0
    wr16(ACnt, 16'd3);
    wr16(APer, 16'd4);
    wr16(ADly, 16'd0);
    go(8'h01, 4, 4, 0, 1, k);
    chk("busy_after_start", {15'd0, busy}, 16'h1);
    wait_idle(k + 13, "idle_c3_p4");
    rd(ACtl, 7'd0, 8'h02);

    // COUNT=2 PERIOD=0 DELAY=5, level 1 with start
    wr16(ACnt, 16'd2);
    wr16(APer, 16'd0);
    wr16(ADly, 16'd5);
    go(8'h05, 3, 0, 5, 1, k);
    wait_idle(k + 8, "idle_c2_p0_d5");
    rd(ACtl, 7'd0, 8'h02);

    // COUNT=9 PERIOD=10, ignored restart, abort at k+25
    wr16(ACnt, 16'd9);
    wr16(APer, 16'd10);
    wr16(ADly, 16'd0);
    go(8'h01, 3, 10, 0, 0, k);
    wait_until(k + 14);
    wr(ACtl, 7'd0, 8'h01);
    wait_until(k + 24);
    wr(ACtl, 7'd0, 8'h02);
    wait_idle(k + 26, "idle_after_abort");
    wait_until(k + 45);
    rd(ACtl, 7'd0, 8'h04);

    // Abort while idle, start+abort together while idle: no run
    wr(ACtl, 7'd0, 8'h06);
    wr(ACtl, 7'd0, 8'h07);
    #1 chk("start_abort_idle_busy", {15'd0, busy}, 16'h0);
    @(posedge clk_usb);
    #1;

    // COUNT=1 PERIOD=3, PERIOD=7 written mid-run applies to the next start only
    wr16(ACnt, 16'd1);
    wr16(APer, 16'd3);
    go(8'h05, 2, 3, 0, 1, k);
    wr16(APer, 16'd7);
    wait_idle(k + 4, "idle_p3_shadow");
    go(8'h05, 2, 7, 0, 1, k);
    wait_idle(k + 8, "idle_p7_next");
    rd(ACtl, 7'd0, 8'h06);

    // COUNT=5 PERIOD=3, async reset at k+3, then full restart
    go(8'h00, 0, 0, 0, 0, k);
    wr16(ACnt, 16'd5);
    wr16(APer, 16'd3);
    go(8'h01, 1, 3, 0, 0, k);
    wait_until(k + 3);
    #1 reset = 1'b1;
    #1;
    chk("midrun_reset_edge_out", {15'd0, edge_out}, 16'h0);
    chk("midrun_reset_busy", {15'd0, busy}, 16'h0);
    lvl = 1'b0;
    @(negedge clk_usb);
    @(posedge clk_usb);
    #1 reset = 1'b0;
    rd(ACtl, 7'd0, 8'h00);
    rd(APer, 7'd0, 8'h00);
    wr16(ACnt, 16'd5);
    wr16(APer, 16'd3);
    go(8'h01, 6, 3, 0, 1, k);
    wait_idle(k + 16, "idle_restart");
    rd(ACtl, 7'd0, 8'h02);

    repeat (5) @(posedge clk_usb);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
